// File: rtl/frac_lut_pkg.sv
// rtl/frac_lut_pkg.sv - configuration layout helpers for the fracturable LUT
package frac_lut_pkg;

   // Control bits that sit above the truth table, MSB first in the config word.
   typedef struct packed {
      logic reg_en;
      logic frac_mode;
   } cfg_ctrl_t;

   localparam int CFG_CTRL_W = $bits(cfg_ctrl_t);
   localparam int TT_LSB     = 0;

   function automatic int cfg_width(input int k);
      return (2 ** k) + CFG_CTRL_W;
   endfunction

   function automatic int FRAC_MODE_BIT(input int k);
      return 2 ** k;
   endfunction

   function automatic int REG_EN_BIT(input int k);
      return (2 ** k) + 1;
   endfunction

endpackage

// File: rtl/frac_lut_cfg_chain.sv
// rtl/frac_lut_cfg_chain.sv - serial shadow chain with length-checked atomic commit
module frac_lut_cfg_chain
   import frac_lut_pkg::*;
#(
   parameter int K = 6
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cfg_en,
   input  logic                    ccff_head,
   output logic                    ccff_tail,
   output logic [cfg_width(K)-1:0] active,
   output logic                    cfg_valid,
   output logic                    cfg_err
);

   localparam int CFG_W = cfg_width(K);
   localparam int CNT_W = $clog2(CFG_W + 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_W + 1);

   logic [CFG_W-1:0] shadow;
   logic [CNT_W-1:0] cnt;
   logic             cfg_en_q;

   assign ccff_tail = shadow[CFG_W-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow    <= '0;
         active    <= '0;
         cnt       <= '0;
         cfg_en_q  <= 1'b0;
         cfg_valid <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         cfg_en_q <= cfg_en;
         if (cfg_en) begin
            shadow <= {shadow[CFG_W-2:0], ccff_head};
            // Each new shift session restarts the count; saturation keeps overlong loads detectable.
            if (!cfg_en_q)
               cnt <= CNT_ONE;
            else if (cnt != CNT_SAT)
               cnt <= cnt + CNT_ONE;
         end else if (cfg_en_q) begin
            if (cnt == CNT_FULL) begin
               active    <= shadow;
               cfg_valid <= 1'b1;
            end else begin
               cfg_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/frac_lut_cfg.sv
// rtl/frac_lut_cfg.sv - K-input fracturable LUT with config chain and optional output register
module frac_lut_cfg
   import frac_lut_pkg::*;
#(
   parameter int K = 6
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         cfg_en,
   input  logic         ccff_head,
   output logic         ccff_tail,
   input  logic [K-1:0] in,
   output logic         lutk_out,
   output logic [1:0]   lutk1_out,
   output logic         cfg_valid,
   output logic         cfg_err
);

   localparam int CFG_W = cfg_width(K);
   localparam int TT_W  = 2 ** K;

   logic [CFG_W-1:0] active;
   logic [TT_W-1:0]  tt;
   logic             frac_mode;
   logic             reg_en;
   logic             hi;
   logic [K-1:0]     idx_k;
   logic [K-1:0]     idx_a;
   logic [K-1:0]     idx_b;
   logic [2:0]       comb;
   logic [2:0]       out_q;
   logic [2:0]       out_sel;

   frac_lut_cfg_chain #(.K(K)) u_chain (
      .clk       (clk),
      .reset_n   (reset_n),
      .cfg_en    (cfg_en),
      .ccff_head (ccff_head),
      .ccff_tail (ccff_tail),
      .active    (active),
      .cfg_valid (cfg_valid),
      .cfg_err   (cfg_err)
   );

   assign tt        = active[TT_LSB +: TT_W];
   assign frac_mode = active[FRAC_MODE_BIT(K)];
   assign reg_en    = active[REG_EN_BIT(K)];

   // In fractured mode the top input is ignored and the upper half of the table drives lutk_out.
   assign hi    = in[K-1] | frac_mode;
   assign idx_k = {hi,   in[K-2:0]};
   assign idx_a = {1'b0, in[K-2:0]};
   assign idx_b = {1'b1, in[K-2:0]};

   assign comb = {tt[idx_k], tt[idx_a], tt[idx_b]} & {3{cfg_valid}};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         out_q <= '0;
      else
         out_q <= comb;
   end

   assign out_sel   = reg_en ? out_q : comb;
   assign lutk_out  = out_sel[2];
   assign lutk1_out = out_sel[1:0];

endmodule

// File: tb/tb_frac_lut_cfg.sv
// tb/tb_frac_lut_cfg.sv - directed self-checking bench for frac_lut_cfg (K=6)
module tb_frac_lut_cfg;

   logic       clk;
   logic       reset_n;
   logic       cfg_en;
   logic       ccff_head;
   logic       ccff_tail;
   logic [5:0] in;
   logic       lutk_out;
   logic [1:0] lutk1_out;
   logic       cfg_valid;
   logic       cfg_err;

   int total;
   int bad;

   frac_lut_cfg #(.K(6)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cfg_en    (cfg_en),
      .ccff_head (ccff_head),
      .ccff_tail (ccff_tail),
      .in        (in),
      .lutk_out  (lutk_out),
      .lutk1_out (lutk1_out),
      .cfg_valid (cfg_valid),
      .cfg_err   (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shifts the top n bits of cfg MSB first, then drops cfg_en across the commit edge.
   task automatic load(input logic [65:0] cfg, input int n);
      cfg_en = 1'b1;
      for (int i = 0; i < n; i++) begin
         ccff_head = cfg[65-i];
         @(posedge clk); #1;
      end
      cfg_en = 1'b0;
      ccff_head = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; cfg_en = 1'b0; ccff_head = 1'b0; in = 6'h3F;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      total++; if (lutk_out !== 1'b0) begin bad++; $display("FAIL reset_lutk got=%b want=0", lutk_out); end
      total++; if (lutk1_out !== 2'b00) begin bad++; $display("FAIL reset_lutk1 got=%b want=00", lutk1_out); end
      total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", cfg_valid); end
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", cfg_err); end
      total++; if (ccff_tail !== 1'b0) begin bad++; $display("FAIL reset_tail got=%b want=0", ccff_tail); end
   endtask

   task automatic test_basic();
      load({1'b0, 1'b0, 64'h8000_0000_0000_0001}, 66);
      total++; if (cfg_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", cfg_valid); end
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", cfg_err); end
      in = 6'h00; #1;
      total++; if (lutk_out !== 1'b1) begin bad++; $display("FAIL basic_in00 got=%b want=1", lutk_out); end
      total++; if (lutk1_out !== 2'b10) begin bad++; $display("FAIL basic_in00_k1 got=%b want=10", lutk1_out); end
      in = 6'h3F; #1;
      total++; if (lutk_out !== 1'b1) begin bad++; $display("FAIL basic_in3f got=%b want=1", lutk_out); end
      total++; if (lutk1_out !== 2'b01) begin bad++; $display("FAIL basic_in3f_k1 got=%b want=01", lutk1_out); end
      in = 6'h01; #1;
      total++; if (lutk_out !== 1'b0) begin bad++; $display("FAIL basic_in01 got=%b want=0", lutk_out); end
      total++; if (lutk1_out !== 2'b00) begin bad++; $display("FAIL basic_in01_k1 got=%b want=00", lutk1_out); end
   endtask

   task automatic test_frac();
      load({1'b0, 1'b1, 64'hFFFF_FFFF_0000_0000}, 66);
      in = 6'h00; #1;
      total++; if (lutk_out !== 1'b1) begin bad++; $display("FAIL frac_in00 got=%b want=1", lutk_out); end
      total++; if (lutk1_out !== 2'b01) begin bad++; $display("FAIL frac_in00_k1 got=%b want=01", lutk1_out); end
      in = 6'h20; #1;
      total++; if (lutk_out !== 1'b1) begin bad++; $display("FAIL frac_in20 got=%b want=1", lutk_out); end
      total++; if (lutk1_out !== 2'b01) begin bad++; $display("FAIL frac_in20_k1 got=%b want=01", lutk1_out); end
   endtask

   task automatic test_reg();
      in = 6'h00;
      load({1'b1, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA}, 66);
      @(posedge clk); #1;
      total++; if (lutk_out !== 1'b0) begin bad++; $display("FAIL reg_settle got=%b want=0", lutk_out); end
      in = 6'h01; #1;
      total++; if (lutk_out !== 1'b0) begin bad++; $display("FAIL reg_lag got=%b want=0", lutk_out); end
      @(posedge clk); #1;
      total++; if (lutk_out !== 1'b1) begin bad++; $display("FAIL reg_one_clk got=%b want=1", lutk_out); end
      total++; if (lutk1_out !== 2'b11) begin bad++; $display("FAIL reg_one_clk_k1 got=%b want=11", lutk1_out); end
   endtask

   task automatic test_bad_len();
      load({1'b0, 1'b0, 64'h5555_5555_5555_5555}, 65);
      total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL bad_err got=%b want=1", cfg_err); end
      total++; if (cfg_valid !== 1'b1) begin bad++; $display("FAIL bad_valid got=%b want=1", cfg_valid); end
      in = 6'h00; @(posedge clk); #1;
      total++; if (lutk_out !== 1'b0) begin bad++; $display("FAIL bad_keep_in00 got=%b want=0", lutk_out); end
      in = 6'h01; #1;
      total++; if (lutk_out !== 1'b0) begin bad++; $display("FAIL bad_keep_reg got=%b want=0", lutk_out); end
      @(posedge clk); #1;
      total++; if (lutk_out !== 1'b1) begin bad++; $display("FAIL bad_keep_in01 got=%b want=1", lutk_out); end
      load({1'b0, 1'b0, 64'h5555_5555_5555_5555}, 66);
      in = 6'h00; #1;
      total++; if (lutk_out !== 1'b1) begin bad++; $display("FAIL good_after_bad got=%b want=1", lutk_out); end
      total++; if (lutk1_out !== 2'b11) begin bad++; $display("FAIL good_after_bad_k1 got=%b want=11", lutk1_out); end
      total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", cfg_err); end
   endtask

   task automatic test_reset_mid_shift();
      logic [65:0] c;
      c = {1'b1, 1'b0, 64'h0F0F_0F0F_0F0F_0F0F};
      in = 6'h00;
      cfg_en = 1'b1;
      for (int i = 0; i < 30; i++) begin
         ccff_head = c[65-i];
         @(posedge clk); #1;
      end
      total++; if (lutk_out !== 1'b1) begin bad++; $display("FAIL shift_keeps_old got=%b want=1", lutk_out); end
      reset_n = 1'b0; #1;
      total++; if (lutk_out !== 1'b0) begin bad++; $display("FAIL arst_lutk got=%b want=0", lutk_out); end
      total++; if (lutk1_out !== 2'b00) begin bad++; $display("FAIL arst_lutk1 got=%b want=00", lutk1_out); end
      total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", cfg_valid); end
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL arst_err got=%b want=0", cfg_err); end
      total++; if (ccff_tail !== 1'b0) begin bad++; $display("FAIL arst_tail got=%b want=0", ccff_tail); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int i = 0; i < 66; i++) begin
         ccff_head = c[65-i];
         @(posedge clk); #1;
      end
      total++; if (ccff_tail !== c[65]) begin bad++; $display("FAIL tail_replay got=%b want=%b", ccff_tail, c[65]); end
      total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL valid_before_commit got=%b want=0", cfg_valid); end
      cfg_en = 1'b0;
      @(posedge clk); #1;
      total++; if (cfg_valid !== 1'b1) begin bad++; $display("FAIL post_rst_commit got=%b want=1", cfg_valid); end
      total++; if (lutk_out !== 1'b0) begin bad++; $display("FAIL post_rst_reg_lag got=%b want=0", lutk_out); end
      @(posedge clk); #1;
      total++; if (lutk_out !== 1'b1) begin bad++; $display("FAIL post_rst_lutk got=%b want=1", lutk_out); end
      total++; if (lutk1_out !== 2'b11) begin bad++; $display("FAIL post_rst_lutk1 got=%b want=11", lutk1_out); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic();
      test_frac();
      test_reg();
      test_bad_len();
      test_reset_mid_shift();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
